// File: rtl/nexys_pkg.sv
// Board-level constants shared by the Nexys4 front-end blocks: button bit indices,
// the system clock rate and the default timing counts derived from it.
package nexys_pkg;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;

  localparam int CLK_HZ = 100_000_000;

  // 20 ms debounce window, 0.5 s first repeat, 0.1 s repeat period.
  localparam int DEBOUNCE_CYC_DEF  = CLK_HZ / 50;
  localparam int REPEAT_DELAY_DEF  = CLK_HZ / 2;
  localparam int REPEAT_PERIOD_DEF = CLK_HZ / 10;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One push-button channel: 2-flop synchroniser, stable-count debouncer,
// press edge detector and optional hold-to-repeat strobe generator.
module btn_debounce_ch
  import nexys_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW = cnt_width(DEBOUNCE_CYC);
  localparam int RW = cnt_width(RPT_MAX);

  localparam logic [DW-1:0] DEB_TERM = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DLY_TERM = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_TERM = RW'(REPEAT_PERIOD - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          first_q, first_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  always_comb begin
    level_d = level_q;
    dcnt_d  = '0;
    pulse_d = 1'b0;
    rcnt_d  = rcnt_q;
    first_d = first_q;

    // A single sample back at the accepted level drops dcnt to zero, restarting the window.
    if (s2_q != level_q) begin
      if (dcnt_q == DEB_TERM) begin
        level_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    if (level_d && !level_q) begin
      pulse_d = 1'b1;
      rcnt_d  = '0;
      first_d = 1'b1;
    end else if (!level_d) begin
      rcnt_d  = '0;
      first_d = 1'b0;
    end else if (REPEAT_EN != 0) begin
      if (first_q && (rcnt_q == DLY_TERM)) begin
        pulse_d = 1'b1;
        rcnt_d  = '0;
        first_d = 1'b0;
      end else if (!first_q && (rcnt_q == PER_TERM)) begin
        pulse_d = 1'b1;
        rcnt_d  = '0;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      first_q <= 1'b0;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      first_q <= first_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// Nexys4 push-button conditioner: one independent debounce/pulse channel per button,
// feeding BTNL/BTNR/BTNU/BTND strobes to the hex-digit entry stage.
module btn_pulse_gen
  import nexys_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : gen_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw[i]),
      .btn_level(btn_level[i]),
      .btn_pulse(btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen with short timing parameters; a second instance
// with repeat disabled shares the stimulus and is checked during the clean-press case.
module tb_btn_pulse_gen;
  import nexys_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_pulse;
  logic [3:0] level_nr, pulse_nr;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  btn_pulse_gen #(
    .NUM_BTN(4), .DEBOUNCE_CYC(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  btn_pulse_gen #(
    .NUM_BTN(4), .DEBOUNCE_CYC(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(level_nr), .btn_pulse(pulse_nr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] raw);
    btn_raw = raw;
  endtask

  // Advance to just after the next rising edge so outputs are stable when sampled.
  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) waitEdge();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0000);
    #1;
    checkOutput("reset level", 32'(btn_level), 32'h0);
    checkOutput("reset pulse", 32'(btn_pulse), 32'h0);
    idle(3);
    checkOutput("reset level held", 32'(btn_level), 32'h0);
    checkOutput("reset pulse_nr held", 32'(pulse_nr), 32'h0);
    rst_n = 1'b1;
    idle(2);

    $display("[TB] clean press on BTN_L");
    applyStimulus(4'b0001);
    for (int e = 0; e < 32; e++) begin
      logic exp_p;
      waitEdge();
      exp_p = (e == 5) || (e >= 15 && ((e - 15) % 3 == 0));
      checkOutput($sformatf("c1 pulse e%0d", e), 32'(btn_pulse[BTN_L]), 32'(exp_p));
      checkOutput($sformatf("c1 level e%0d", e), 32'(btn_level[BTN_L]), 32'(e >= 5));
      checkOutput($sformatf("c1 other e%0d", e), 32'(btn_pulse[3:1]), 32'h0);
      checkOutput($sformatf("c1 nr pulse e%0d", e), 32'(pulse_nr[BTN_L]), 32'(e == 5));
      checkOutput($sformatf("c1 nr level e%0d", e), 32'(level_nr[BTN_L]), 32'(e >= 5));
    end
    applyStimulus(4'b0000);
    idle(12);
    checkOutput("c1 released level", 32'(btn_level), 32'h0);
    checkOutput("c1 released nr level", 32'(level_nr), 32'h0);

    $display("[TB] bouncing press on BTN_U");
    for (int e = 0; e < 15; e++) begin
      if (e < 4) applyStimulus((e % 2 == 0) ? 4'b0100 : 4'b0000);
      else       applyStimulus(4'b0100);
      waitEdge();
      checkOutput($sformatf("c2 pulse e%0d", e), 32'(btn_pulse[BTN_U]), 32'(e == 9));
      checkOutput($sformatf("c2 level e%0d", e), 32'(btn_level[BTN_U]), 32'(e >= 9));
    end
    applyStimulus(4'b0000);
    idle(12);

    $display("[TB] short glitch on BTN_R");
    for (int e = 0; e < 13; e++) begin
      applyStimulus((e < 3) ? 4'b0010 : 4'b0000);
      waitEdge();
      checkOutput($sformatf("c3 pulse e%0d", e), 32'(btn_pulse[BTN_R]), 32'h0);
      checkOutput($sformatf("c3 level e%0d", e), 32'(btn_level[BTN_R]), 32'h0);
    end

    $display("[TB] press and release on BTN_D");
    for (int e = 0; e < 21; e++) begin
      applyStimulus((e < 8) ? 4'b1000 : 4'b0000);
      waitEdge();
      checkOutput($sformatf("c4 pulse e%0d", e), 32'(btn_pulse[BTN_D]), 32'(e == 5));
      checkOutput($sformatf("c4 level e%0d", e), 32'(btn_level[BTN_D]), 32'(e >= 5 && e < 13));
    end
    idle(4);
    applyStimulus(4'b1000);
    for (int e = 0; e < 18; e++) begin
      waitEdge();
      checkOutput($sformatf("c4 repress pulse e%0d", e), 32'(btn_pulse[BTN_D]),
                  32'(e == 5 || e == 15));
    end
    applyStimulus(4'b0000);
    idle(12);

    $display("[TB] simultaneous BTN_L and BTN_U");
    applyStimulus(4'b0101);
    for (int e = 0; e < 8; e++) begin
      waitEdge();
      checkOutput($sformatf("c5 pulse e%0d", e), 32'(btn_pulse), (e == 5) ? 32'h5 : 32'h0);
    end
    applyStimulus(4'b0000);
    idle(15);

    $display("[TB] reset while BTN_L repeats");
    applyStimulus(4'b0001);
    for (int e = 0; e < 16; e++) begin
      waitEdge();
      checkOutput($sformatf("c6 pulse e%0d", e), 32'(btn_pulse), (e == 5 || e == 15) ? 32'h1 : 32'h0);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("c6 async pulse", 32'(btn_pulse), 32'h0);
    checkOutput("c6 async level", 32'(btn_level), 32'h0);
    idle(3);
    checkOutput("c6 held pulse", 32'(btn_pulse), 32'h0);
    rst_n = 1'b1;
    for (int e = 0; e < 9; e++) begin
      waitEdge();
      checkOutput($sformatf("c6 fresh pulse e%0d", e), 32'(btn_pulse), (e == 5) ? 32'h1 : 32'h0);
      checkOutput($sformatf("c6 fresh level e%0d", e), 32'(btn_level[BTN_L]), 32'(e >= 5));
    end
    applyStimulus(4'b0000);
    idle(4);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
